// File: rtl/ex_stage_skid_reg.sv
// ex_stage_skid_reg
//   EX/MEM pipeline register with a 2-entry skid buffer and valid/ready
//   handshake. The input ready is registered, so EX never waits on a
//   combinational path from MEM. Exceptions are tagged at capture with this
//   priority: external interrupt, then ALU overflow, then the upstream code.
//
// Ports
//   clk, reset_            clock (posedge), async active-low reset
//   InValid / InReady      upstream handshake (InReady is a flop)
//   Flush                  drop every held and same-cycle beat
//   IntDetect, ALUOF       exception sources, sampled on accept
//   ALUOut, ID*            incoming beat fields
//   OutValid / OutReady    downstream handshake
//   EX*, EXOut             registered beat fields
//   StallCnt, FlushCnt     perf counters
//
// Configuration
//   EX_STAGE_PERF_EN  when defined, builds the 32-bit stall and flush
//                     counters; when undefined both outputs are tied to 0.
module ex_stage_skid_reg #(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 30,
  parameter int REG_AW     = 5,
  parameter int MEMOP_W    = 2,
  parameter int CTRLOP_W   = 2,
  parameter int EXP_W      = 3,
  parameter int MEMOP_NOP  = 0,
  parameter int CTRLOP_NOP = 0,
  parameter int EXP_NONE   = 0,
  parameter int EXP_INT    = 1,
  parameter int EXP_OVF    = 3
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic                InValid,
  output logic                InReady,
  input  logic                Flush,
  input  logic                IntDetect,
  input  logic [DATA_W-1:0]   ALUOut,
  input  logic                ALUOF,
  input  logic [PC_W-1:0]     IDPC,
  input  logic                IDEn,
  input  logic                IDBrFlag,
  input  logic [MEMOP_W-1:0]  IDMemOp,
  input  logic [DATA_W-1:0]   IDMemWrData,
  input  logic [CTRLOP_W-1:0] IDCtrlOp,
  input  logic [REG_AW-1:0]   IDDstAddr,
  input  logic                IDGPRWE_,
  input  logic [EXP_W-1:0]    IDExpCode,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [PC_W-1:0]     EXPC,
  output logic                EXEn,
  output logic                EXBrFlag,
  output logic [MEMOP_W-1:0]  EXMemOp,
  output logic [DATA_W-1:0]   EXMemWrData,
  output logic [CTRLOP_W-1:0] EXCtrlOp,
  output logic [REG_AW-1:0]   EXDstAddr,
  output logic                EXGPRWE_,
  output logic [EXP_W-1:0]    EXExpCode,
  output logic [DATA_W-1:0]   EXOut,
  output logic [31:0]         StallCnt,
  output logic [31:0]         FlushCnt
);

  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic                en;
    logic                br;
    logic [MEMOP_W-1:0]  memop;
    logic [DATA_W-1:0]   wrdata;
    logic [CTRLOP_W-1:0] ctrlop;
    logic [REG_AW-1:0]   dst;
    logic                gprwe_;
    logic [EXP_W-1:0]    exp;
    logic [DATA_W-1:0]   out;
  } beat_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  function automatic beat_t rst_beat();
    beat_t b;
    b        = '0;
    b.memop  = MEMOP_W'(MEMOP_NOP);
    b.ctrlop = CTRLOP_W'(CTRLOP_NOP);
    b.exp    = EXP_W'(EXP_NONE);
    b.gprwe_ = 1'b1;
    return b;
  endfunction

  state_e state_q, state_d;
  beat_t  out_q, out_d, skid_q, skid_d, cap;
  logic   ready_q, ready_d;
  logic   accept, consume;

  assign OutValid = (state_q != EMPTY);
  assign InReady  = ready_q;
  assign accept   = InValid & ready_q;
  assign consume  = OutValid & OutReady;

  // Exception rewrite: a tagged beat keeps only PC/En/BrFlag so MEM sees a
  // harmless no-op carrying the faulting PC.
  always_comb begin
    cap        = rst_beat();
    cap.pc     = IDPC;
    cap.en     = IDEn;
    cap.br     = IDBrFlag;
    if (IntDetect) begin
      cap.exp  = EXP_W'(EXP_INT);
    end else if (ALUOF) begin
      cap.exp  = EXP_W'(EXP_OVF);
    end else begin
      cap.memop  = IDMemOp;
      cap.wrdata = IDMemWrData;
      cap.ctrlop = IDCtrlOp;
      cap.dst    = IDDstAddr;
      cap.gprwe_ = IDGPRWE_;
      cap.exp    = IDExpCode;
      cap.out    = ALUOut;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (Flush) begin
      state_d = EMPTY;
      out_d   = rst_beat();
      skid_d  = rst_beat();
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          out_d   = cap;
          state_d = ONE;
        end
        ONE: begin
          if (accept && consume) begin
            out_d   = cap;
          end else if (accept) begin
            skid_d  = cap;
            state_d = FULL;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: if (consume) begin
          out_d   = skid_q;
          skid_d  = rst_beat();
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Ready is computed from the next state so it is a plain flop output.
  assign ready_d = (state_d != FULL);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= EMPTY;
      out_q   <= rst_beat();
      skid_q  <= rst_beat();
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign EXPC        = out_q.pc;
  assign EXEn        = out_q.en;
  assign EXBrFlag    = out_q.br;
  assign EXMemOp     = out_q.memop;
  assign EXMemWrData = out_q.wrdata;
  assign EXCtrlOp    = out_q.ctrlop;
  assign EXDstAddr   = out_q.dst;
  assign EXGPRWE_    = out_q.gprwe_;
  assign EXExpCode   = out_q.exp;
  assign EXOut       = out_q.out;

`ifdef EX_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Counters wrap naturally and are cleared only by reset.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (OutValid && !OutReady) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (Flush)                 flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_ex_stage_skid_reg.sv
module tb_ex_stage_skid_reg;

`ifdef EX_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_;
  logic        InValid, InReady, Flush, IntDetect, ALUOF, OutValid, OutReady;
  logic [31:0] ALUOut, IDMemWrData, EXMemWrData, EXOut, StallCnt, FlushCnt;
  logic [29:0] IDPC, EXPC;
  logic        IDEn, IDBrFlag, IDGPRWE_, EXEn, EXBrFlag, EXGPRWE_;
  logic [1:0]  IDMemOp, IDCtrlOp, EXMemOp, EXCtrlOp;
  logic [4:0]  IDDstAddr, EXDstAddr;
  logic [2:0]  IDExpCode, EXExpCode;

  always #5 clk = ~clk;

  ex_stage_skid_reg dut (
    .clk(clk), .reset_(reset_), .InValid(InValid), .InReady(InReady),
    .Flush(Flush), .IntDetect(IntDetect), .ALUOut(ALUOut), .ALUOF(ALUOF),
    .IDPC(IDPC), .IDEn(IDEn), .IDBrFlag(IDBrFlag), .IDMemOp(IDMemOp),
    .IDMemWrData(IDMemWrData), .IDCtrlOp(IDCtrlOp), .IDDstAddr(IDDstAddr),
    .IDGPRWE_(IDGPRWE_), .IDExpCode(IDExpCode), .OutValid(OutValid),
    .OutReady(OutReady), .EXPC(EXPC), .EXEn(EXEn), .EXBrFlag(EXBrFlag),
    .EXMemOp(EXMemOp), .EXMemWrData(EXMemWrData), .EXCtrlOp(EXCtrlOp),
    .EXDstAddr(EXDstAddr), .EXGPRWE_(EXGPRWE_), .EXExpCode(EXExpCode),
    .EXOut(EXOut), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  typedef struct packed {
    logic [29:0] pc;
    logic        en, br;
    logic [1:0]  memop;
    logic [31:0] wd;
    logic [1:0]  ctrl;
    logic [4:0]  dst;
    logic        gwe_;
    logic [2:0]  exp;
    logic [31:0] out;
  } beat_t;

  localparam beat_t RST = '{pc: '0, en: 1'b0, br: 1'b0, memop: 2'd0, wd: '0,
                            ctrl: 2'd0, dst: '0, gwe_: 1'b1, exp: 3'd0, out: '0};

  beat_t obs;
  assign obs = {EXPC, EXEn, EXBrFlag, EXMemOp, EXMemWrData, EXCtrlOp,
                EXDstAddr, EXGPRWE_, EXExpCode, EXOut};

  // Reference model: a FIFO of at most two expected beats.
  beat_t q[$];
  int    npass = 0, nfail = 0, ntot = 0;
  int    stall_m = 0, flush_m = 0;
  bit    rst_vals = 1'b1;

  task automatic chk(input string tag, input logic [159:0] o, input logic [159:0] e);
    ntot++;
    assert (o === e) npass++;
    else begin
      nfail++;
      $error("FAIL %s got %h want %h", tag, o, e);
    end
  endtask

  function automatic beat_t expect_cap();
    beat_t b = RST;
    b.pc = IDPC; b.en = IDEn; b.br = IDBrFlag;
    if (IntDetect)  b.exp = 3'd1;
    else if (ALUOF) b.exp = 3'd3;
    else begin
      b.memop = IDMemOp; b.wd = IDMemWrData; b.ctrl = IDCtrlOp;
      b.dst = IDDstAddr; b.gwe_ = IDGPRWE_; b.exp = IDExpCode; b.out = ALUOut;
    end
    return b;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".valid"}, 160'(OutValid), 160'(q.size() > 0));
    chk({tag, ".ready"}, 160'(InReady), 160'(q.size() < 2));
    if (q.size() > 0)  chk({tag, ".beat"}, 160'(obs), 160'(q[0]));
    else if (rst_vals) chk({tag, ".rstbeat"}, 160'(obs), 160'(RST));
    chk({tag, ".stallcnt"}, 160'(StallCnt), 160'(PERF ? 32'(stall_m) : 32'd0));
    chk({tag, ".flushcnt"}, 160'(FlushCnt), 160'(PERF ? 32'(flush_m) : 32'd0));
  endtask

  task automatic cyc(input string tag, input bit iv, input bit ordy, input bit fl,
                     input bit intd, input bit ovf);
    bit rdy, cons;
    beat_t nb;
    InValid = iv; OutReady = ordy; Flush = fl; IntDetect = intd; ALUOF = ovf;
    ALUOut = $urandom; IDPC = 30'($urandom); IDEn = 1'($urandom);
    IDBrFlag = 1'($urandom); IDMemOp = 2'($urandom); IDMemWrData = $urandom;
    IDCtrlOp = 2'($urandom); IDDstAddr = 5'($urandom); IDGPRWE_ = 1'($urandom);
    IDExpCode = 3'($urandom);
    nb = expect_cap();
    @(posedge clk);
    if (q.size() > 0 && !ordy) stall_m++;
    if (fl) begin
      flush_m++;
      q.delete();
      rst_vals = 1'b1;
    end else begin
      rdy  = (q.size() < 2);
      cons = (q.size() > 0) && ordy;
      if (cons) void'(q.pop_front());
      if (iv && rdy) begin
        q.push_back(nb);
        rst_vals = 1'b0;
      end
    end
    #1;
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_ = 1'b0;
    #1;
    q.delete(); stall_m = 0; flush_m = 0; rst_vals = 1'b1;
    check_state(tag);
    @(negedge clk);
    reset_ = 1'b1;
  endtask

  initial begin
    reset_ = 1'b1;
    InValid = 0; OutReady = 0; Flush = 0; IntDetect = 0; ALUOF = 0;
    ALUOut = 0; IDPC = 0; IDEn = 0; IDBrFlag = 0; IDMemOp = 0; IDMemWrData = 0;
    IDCtrlOp = 0; IDDstAddr = 0; IDGPRWE_ = 0; IDExpCode = 0;
    #2;

    // 1. reset then idle
    do_reset("reset");
    repeat (2) cyc("idle", 0, 1, 0, 0, 0);

    // 2. streaming at full throughput
    repeat (4) cyc("stream", 1, 1, 0, 0, 0);
    cyc("stream_end", 0, 1, 0, 0, 0);

    // 3. back-pressure: three offered, two held, then in-order drain
    repeat (3) cyc("bp_fill", 1, 0, 0, 0, 0);
    repeat (3) cyc("bp_drain", 0, 1, 0, 0, 0);

    // 4. exception tagging priority
    cyc("exc_int_ovf", 1, 1, 0, 1, 1);
    cyc("exc_ovf", 1, 1, 0, 0, 1);
    cyc("exc_int", 1, 1, 0, 1, 0);
    cyc("int_no_accept", 0, 1, 0, 1, 0);

    // 5. flush while full, with an incoming beat and a same-cycle consume
    repeat (2) cyc("fill", 1, 0, 0, 0, 0);
    cyc("flush_full", 1, 1, 1, 0, 0);
    cyc("after_flush", 0, 1, 0, 0, 0);

    // 6. perf counters from a clean reset
    do_reset("reset2");
    cyc("pf_load", 1, 0, 0, 0, 0);
    repeat (5) cyc("pf_stall", 0, 0, 0, 0, 0);
    cyc("pf_flush1", 0, 1, 1, 0, 0);
    cyc("pf_flush2", 0, 1, 1, 0, 0);
    chk("perf_stall5", 160'(StallCnt), 160'(PERF ? 32'd5 : 32'd0));
    chk("perf_flush2", 160'(FlushCnt), 160'(PERF ? 32'd2 : 32'd0));

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cyc("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7),
          1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 7) == 0));

    // reset mid-operation with beats held
    repeat (2) cyc("pre_rst", 1, 0, 0, 0, 0);
    do_reset("mid_reset");
    cyc("post_rst", 0, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
